dsp_preadd_mult: RTL and testbench
==================================

// Module: dsp_preadd_mult
// PURPOSE
//  Pre-adder / multiplier stage of the DSP48A1 slice model. Sits directly downstream of the
//  A/B/D input register-mux stages and feeds the post-adder/accumulator stage.
//  Computes (D +/- B) or B, optionally registers it (B1), multiplies it by A (optionally
//  registered, A1) to give a signed 36-bit product (optionally registered, M).
//  A valid tag travels with the data for verification and for downstream use.
// PARAMETERS
//  A1REG      1  1 = A1 pipeline register present, 0 = combinational bypass
//  B1REG      1  1 = B1 register present on the pre-adder output / BCOUT, 0 = bypass
//  MREG       1  1 = M register present on the multiplier output, 0 = bypass
//  OPMODEREG  1  1 = opmode register present, 0 = bypass
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset: one clock; synchronous, active-low
//  ce_a        in   1   clock enable, A1 register
//  ce_b        in   1   clock enable, B1 register and stage-1 valid tag
//  ce_m        in   1   clock enable, M register and stage-2 valid tag
//  ce_opmode   in   1   clock enable, opmode register
//  opmode      in   8   DSP48A1 opmode; bit6 = pre-adder subtract, bit4 = select pre-adder
//  in_valid    in   1   data on d_in/b_in/a_in is valid
//  d_in        in   18  D operand (from D register-mux stage), two's complement
//  b_in        in   18  B operand (from B0 register-mux stage), two's complement
//  a_in        in   18  A operand (from A0 register-mux stage), two's complement
//  bcout       out  18  B1 stage output (pre-adder result or B), also the B cascade out
//  m_out       out  36  signed product, to post-adder X mux
//  m_valid     out  1   valid tag aligned with m_out
//  opmode_out  out  8   registered/bypassed opmode, forwarded to the post-adder stage
// BEHAVIOUR
//  - Every register updates on posedge clk. Priority: !rst_n (clear to 0) > ce (load) > hold.
//  - Reset values: bcout=0, m_out=0, m_valid=0, opmode_out=0. This holds for every stage
//    that has its register present. Stages in bypass follow their inputs even during reset.
//  - opm = OPMODEREG ? opmode_r : opmode. Pre-adder control is taken from opm in the same
//    cycle as d_in/b_in.
//  - pre = opm[6] ? (d_in - b_in) : (d_in + b_in), computed modulo 2^18 (carry/borrow dropped).
//  - b1_d = opm[4] ? pre : b_in. bcout = B1REG ? b1_r : b1_d.
//  - a1 = A1REG ? a1_r : a_in.
//  - prod = $signed(a1) * $signed(bcout). The result is exact and 36 bits wide, with no saturation.
//  - m_out = MREG ? m_r : prod.
//  - Latency from d_in/b_in to m_out = B1REG + MREG cycles (0..2). A1REG must equal B1REG for
//    aligned operands; a mismatch is a configuration error (simulation $error at time 0).
//  - Valid pipeline: v1 = B1REG ? v1_r (loaded with in_valid on ce_b) : in_valid.
//    m_valid = MREG ? vm_r (loaded with v1 on ce_m) : v1. The valid tag never gates data regs.
//  - ce low on a stage: that stage holds its data and its tag. Downstream stages may still
//    load, so a held stage re-presents the same sample (duplicate valid is legal).
//  - Reset mid-operation: all in-flight samples are dropped. The next edge with rst_n=1 and ce=1
//    loads fresh data. No partial state survives.
//  - All-bypass config (all params 0): purely combinational path d/b/a -> m_out.
// STRUCTURE
//  - Package dsp48a1_pkg: A_W=18, B_W=18, D_W=18, M_W=36, OPM_W=8, OPM_PRE_SUB=6,
//    OPM_PRE_SEL=4 (shared with the post-adder stage).
//  - Sub-module dsp_pipe_reg #(W, PRESENT): sync active-low clear, ce, bypass mux. It is
//    instantiated for opmode, A1, B1, M, v1, vm.
//  - Top holds only the pre-adder, the selection mux, the multiplier and the config check.
// TESTING
//  1 Reset: rst_n=0 for 2 clk, in_valid=1, all ce=1 -> bcout=0, m_out=0, m_valid=0, opmode_out=0.
//  2 Add, defaults: opmode=0x10, D=5, B=3, A=4, in_valid=1 pulse -> bcout=8 after 1 clk;
//    m_out=32 and m_valid=1 after 2 clk, m_valid=0 the following cycle.
//  3 Subtract: opmode=0x50, D=3, B=5, A=-7 -> bcout=0x3FFFE (-2), m_out=14 after 2 clk.
//  4 Bypass pre-adder, extremes: opmode=0x00, B=0x1FFFF, A=0x20000 -> m_out=-17179738112.
//  5 Wrap: opmode=0x10, D=0x1FFFF, B=1, A=1 -> bcout=0x20000, m_out=0xFFFFE0000 (-131072).
//  6 Hold/reset: after test 2 set ce_m=0 and change inputs -> m_out stays 32 and m_valid stays
//    1. Then rst_n=0 for 1 clk -> m_out=0 next edge. Repeat tests 2-5 with all params 0 and
//    check the result in the same cycle.

Source files
------------

// File: rtl/dsp48a1_pkg.sv
// Shared widths, opmode bit positions and the pre-adder helper for the DSP48A1 slice model.
package dsp48a1_pkg;

  localparam int A_W         = 18;
  localparam int B_W         = 18;
  localparam int D_W         = 18;
  localparam int M_W         = 36;
  localparam int OPM_W       = 8;
  localparam int OPM_PRE_SUB = 6;
  localparam int OPM_PRE_SEL = 4;

  // Pre-adder: D +/- B, wrapping modulo 2^18 (carry/borrow dropped).
  function automatic logic [B_W-1:0] preadd(input logic [D_W-1:0] d,
                                            input logic [B_W-1:0] b,
                                            input logic           sub);
    logic [B_W-1:0] res;
    res = sub ? (d - b) : (d + b);
    return res;
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register: synchronous active-low clear, clock enable, bypass when absent.
module dsp_pipe_reg #(
  parameter int W       = 1,
  parameter bit PRESENT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ce,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (PRESENT) begin : g_reg
    logic [W-1:0] r_q;

    // Clear has priority over load; hold when ce is low.
    always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge (synchronous), and state uses <= so
      // every register in the slice sees pre-edge values.
      if (!rst_n)    r_q <= '0;
      else if (i_ce) r_q <= i_d;
    end

    assign o_q = r_q;
  end else begin : g_bypass
    // Bypassed stage follows its input even during reset; clock controls are unused here.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, clk, rst_n, i_ce};
    assign o_q         = i_d;
  end

endmodule

// File: rtl/dsp_preadd_mult.sv
// Pre-adder / multiplier stage of the DSP48A1 slice: (D +/- B) or B, times A, 36-bit signed product.
module dsp_preadd_mult
  import dsp48a1_pkg::*;
#(
  parameter int A1REG     = 1,
  parameter int B1REG     = 1,
  parameter int MREG      = 1,
  parameter int OPMODEREG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_a,
  input  logic             ce_b,
  input  logic             ce_m,
  input  logic             ce_opmode,
  input  logic [OPM_W-1:0] opmode,
  input  logic             in_valid,
  input  logic [D_W-1:0]   d_in,
  input  logic [B_W-1:0]   b_in,
  input  logic [A_W-1:0]   a_in,
  output logic [B_W-1:0]   bcout,
  output logic [M_W-1:0]   m_out,
  output logic             m_valid,
  output logic [OPM_W-1:0] opmode_out
);

  // A1 and B1 must match or the multiplier sees operands from different samples.
  if (A1REG != B1REG) begin : g_cfg_err
    $error("dsp_preadd_mult: A1REG (%0d) must equal B1REG (%0d)", A1REG, B1REG);
  end

  logic [OPM_W-1:0] w_opm;
  logic [B_W-1:0]   w_pre;
  logic [B_W-1:0]   w_b1_d;
  logic [A_W-1:0]   w_a1;
  logic [M_W-1:0]   w_prod;
  logic             w_v1;

  // Opmode register; its output also steers the pre-adder in this cycle.
  dsp_pipe_reg #(.W(OPM_W), .PRESENT(OPMODEREG != 0)) u_opm_reg (
    .clk(clk), .rst_n(rst_n), .i_ce(ce_opmode), .i_d(opmode), .o_q(w_opm)
  );

  assign opmode_out = w_opm;

  // Pre-adder and B1 source select.
  assign w_pre  = preadd(d_in, b_in, w_opm[OPM_PRE_SUB]);
  assign w_b1_d = w_opm[OPM_PRE_SEL] ? w_pre : b_in;

  dsp_pipe_reg #(.W(B_W), .PRESENT(B1REG != 0)) u_b1_reg (
    .clk(clk), .rst_n(rst_n), .i_ce(ce_b), .i_d(w_b1_d), .o_q(bcout)
  );

  dsp_pipe_reg #(.W(A_W), .PRESENT(A1REG != 0)) u_a1_reg (
    .clk(clk), .rst_n(rst_n), .i_ce(ce_a), .i_d(a_in), .o_q(w_a1)
  );

  // Exact 18x18 signed product; both operands are sign-extended to 36 bits.
  assign w_prod = $signed(w_a1) * $signed(bcout);

  dsp_pipe_reg #(.W(M_W), .PRESENT(MREG != 0)) u_m_reg (
    .clk(clk), .rst_n(rst_n), .i_ce(ce_m), .i_d(w_prod), .o_q(m_out)
  );

  // Valid tag follows the B1 and M stages with the same enables; it never gates data.
  dsp_pipe_reg #(.W(1), .PRESENT(B1REG != 0)) u_v1_reg (
    .clk(clk), .rst_n(rst_n), .i_ce(ce_b), .i_d(in_valid), .o_q(w_v1)
  );

  dsp_pipe_reg #(.W(1), .PRESENT(MREG != 0)) u_vm_reg (
    .clk(clk), .rst_n(rst_n), .i_ce(ce_m), .i_d(w_v1), .o_q(m_valid)
  );

endmodule

// File: tb/tb_dsp_preadd_mult.sv
// Directed bench: fully registered instance plus an all-bypass instance on shared inputs.
module tb_dsp_preadd_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_a, ce_b, ce_m, ce_opmode;
  logic [7:0]  opmode;
  logic        in_valid;
  logic [17:0] d_in, b_in, a_in;

  logic [17:0] bcout_r,   bcout_c;
  logic [35:0] m_out_r,   m_out_c;
  logic        m_valid_r, m_valid_c;
  logic [7:0]  opm_out_r, opm_out_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dsp_preadd_mult #(.A1REG(1), .B1REG(1), .MREG(1), .OPMODEREG(1)) dut_reg (
    .clk(clk), .rst_n(rst_n), .ce_a(ce_a), .ce_b(ce_b), .ce_m(ce_m), .ce_opmode(ce_opmode),
    .opmode(opmode), .in_valid(in_valid), .d_in(d_in), .b_in(b_in), .a_in(a_in),
    .bcout(bcout_r), .m_out(m_out_r), .m_valid(m_valid_r), .opmode_out(opm_out_r)
  );

  dsp_preadd_mult #(.A1REG(0), .B1REG(0), .MREG(0), .OPMODEREG(0)) dut_byp (
    .clk(clk), .rst_n(rst_n), .ce_a(ce_a), .ce_b(ce_b), .ce_m(ce_m), .ce_opmode(ce_opmode),
    .opmode(opmode), .in_valid(in_valid), .d_in(d_in), .b_in(b_in), .a_in(a_in),
    .bcout(bcout_c), .m_out(m_out_c), .m_valid(m_valid_c), .opmode_out(opm_out_c)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [17:0] d, input logic [17:0] b, input logic [17:0] a,
                       input logic v);
    d_in = d; b_in = b; a_in = a; in_valid = v;
  endtask

  initial begin
    rst_n = 1'b0; ce_a = 1'b1; ce_b = 1'b1; ce_m = 1'b1; ce_opmode = 1'b1;
    opmode = 8'h10;
    drive(18'd5, 18'd3, 18'd4, 1'b1);

    // 1: reset clears every registered output, even with valid data and enables high.
    tick(); tick();
    check_eq("rst_bcout",   bcout_r,   0);
    check_eq("rst_m_out",   m_out_r,   0);
    check_eq("rst_m_valid", m_valid_r, 0);
    check_eq("rst_opm_out", opm_out_r, 0);
    // Bypass instance ignores reset.
    check_eq("byp_rst_m_out", m_out_c, 36'd32);

    // 2: add, single valid pulse. Opmode register loads one cycle ahead of the data.
    rst_n = 1'b1;
    drive(18'd0, 18'd0, 18'd0, 1'b0);
    tick();
    check_eq("add_opm_out", opm_out_r, 8'h10);
    drive(18'd5, 18'd3, 18'd4, 1'b1);
    tick();
    check_eq("add_bcout", bcout_r, 18'd8);
    in_valid = 1'b0;
    tick();
    check_eq("add_m_out",   m_out_r,   36'd32);
    check_eq("add_m_valid", m_valid_r, 1);
    tick();
    check_eq("add_m_valid_drop", m_valid_r, 0);

    // 6a: hold with ce_m low while upstream keeps loading.
    drive(18'd5, 18'd3, 18'd4, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("hold_pre_m_valid", m_valid_r, 1);
    ce_m = 1'b0;
    drive(18'd7, 18'd7, 18'd7, 1'b1);
    tick(); tick();
    check_eq("hold_m_out",   m_out_r,   36'd32);
    check_eq("hold_m_valid", m_valid_r, 1);
    check_eq("hold_bcout",   bcout_r,   18'd14);

    // 6b: one-cycle reset beats the held state and drops everything in flight.
    rst_n = 1'b0;
    tick();
    check_eq("midrst_m_out",   m_out_r,   0);
    check_eq("midrst_m_valid", m_valid_r, 0);
    check_eq("midrst_bcout",   bcout_r,   0);
    rst_n = 1'b1;
    ce_m  = 1'b1;

    // 3: subtract, 3 - 5 = -2; -7 * -2 = 14.
    opmode = 8'h50;
    drive(18'd0, 18'd0, 18'd0, 1'b0);
    tick();
    drive(18'd3, 18'd5, 18'h3FFF9, 1'b1);
    tick();
    check_eq("sub_bcout", bcout_r, 18'h3FFFE);
    tick();
    check_eq("sub_m_out", m_out_r, 36'd14);

    // 4: pre-adder bypassed, extreme operands: -131072 * 131071.
    opmode = 8'h00;
    drive(18'h12345, 18'h1FFFF, 18'h20000, 1'b1);
    tick();
    tick();
    check_eq("ext_bcout", bcout_r, 18'h1FFFF);
    tick();
    check_eq("ext_m_out", m_out_r, 36'hC_0002_0000);

    // 5: pre-adder wrap, 0x1FFFF + 1 = 0x20000 (-131072).
    opmode = 8'h10;
    drive(18'd0, 18'd0, 18'd0, 1'b0);
    tick();
    drive(18'h1FFFF, 18'd1, 18'd1, 1'b1);
    tick();
    check_eq("wrap_bcout", bcout_r, 18'h20000);
    tick();
    check_eq("wrap_m_out", m_out_r, 36'hF_FFFE_0000);

    // All-bypass instance: results in the same cycle as the inputs.
    opmode = 8'h10; drive(18'd5, 18'd3, 18'd4, 1'b1); #1;
    check_eq("byp_add_bcout",   bcout_c,   18'd8);
    check_eq("byp_add_m_out",   m_out_c,   36'd32);
    check_eq("byp_add_m_valid", m_valid_c, 1);
    check_eq("byp_opm_out",     opm_out_c, 8'h10);
    in_valid = 1'b0; #1;
    check_eq("byp_valid_low",   m_valid_c, 0);
    opmode = 8'h50; drive(18'd3, 18'd5, 18'h3FFF9, 1'b1); #1;
    check_eq("byp_sub_bcout",   bcout_c,   18'h3FFFE);
    check_eq("byp_sub_m_out",   m_out_c,   36'd14);
    opmode = 8'h00; drive(18'h12345, 18'h1FFFF, 18'h20000, 1'b1); #1;
    check_eq("byp_ext_m_out",   m_out_c,   36'hC_0002_0000);
    opmode = 8'h10; drive(18'h1FFFF, 18'd1, 18'd1, 1'b1); #1;
    check_eq("byp_wrap_bcout",  bcout_c,   18'h20000);
    check_eq("byp_wrap_m_out",  m_out_c,   36'hF_FFFE_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
